// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its queue.
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  localparam int unsigned INSTR_BYTES = 4;

  // Redirect targets are forced onto an instruction boundary.
  function automatic logic [63:0] align_pc(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: power-of-two circular FIFO of {pc, instr} entries with a flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          enq,
  input  fq_entry_t     enq_data,
  input  logic          deq_ready,
  output logic          head_valid,
  output fq_entry_t     head,
  output logic          deq,
  output logic [CW-1:0] count
);

  fq_entry_t     mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_enq_s;

  assign head_valid = (count_r != {CW{1'b0}});
  assign head       = mem_r[rd_ptr_r];
  assign deq        = head_valid & deq_ready;
  assign count      = count_r;
  // A full queue may still accept when the head leaves in the same cycle.
  assign do_enq_s   = enq & ~flush & ((count_r < CW'(DEPTH)) | deq);

  // Pointer and occupancy bookkeeping; flush wins over any transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_enq_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (deq)      rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_enq_s, deq})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_enq_s) mem_r[wr_ptr_r] <= enq_data;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Sequential instruction fetch: pc register, FETCH/HALTED FSM and fetch gating
// in front of a small fetch queue that feeds the consumer handshake.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        halted,
  output logic        misalign_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_r;
  fetch_state_t  state_nxt_s;
  logic [63:0]   pc_r;
  logic          in_range_s;
  logic          slot_avail_s;
  logic          fetch_s;
  logic          deq_s;
  logic [CW-1:0] count_s;
  fq_entry_t     enq_data_s;
  fq_entry_t     head_s;

  // Widened by one bit so a pc near the top of the address space cannot wrap.
  assign in_range_s   = ({1'b0, pc_r} + 65'(INSTR_BYTES - 1)) < 65'(MEM_SIZE);
  assign slot_avail_s = (count_s < CW'(DEPTH)) | deq_s;
  assign enq_data_s   = '{pc: pc_r, instr: imem_instr};
  assign imem_addr    = pc_r;
  assign out_instr    = head_s.instr;
  assign out_pc       = head_s.pc;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: redirect always restarts fetching; running off memory halts.
  always_comb begin
    state_nxt_s = state_r;
    if (redirect_valid) begin
      state_nxt_s = FETCH;
    end else begin
      case (state_r)
        FETCH:   state_nxt_s = in_range_s ? FETCH : HALTED;
        HALTED:  state_nxt_s = HALTED;
        default: state_nxt_s = FETCH;
      endcase
    end
  end

  // FSM outputs: fetch enable, halted flag and misaligned-redirect pulse.
  always_comb begin
    fetch_s      = 1'b0;
    halted       = 1'b0;
    misalign_err = redirect_valid & (redirect_pc[1:0] != 2'b00) & ~reset;
    case (state_r)
      FETCH: begin
        fetch_s = ~redirect_valid & in_range_s & slot_avail_s;
        halted  = 1'b0;
      end
      HALTED: begin
        fetch_s = 1'b0;
        halted  = 1'b1;
      end
      default: begin
        fetch_s = 1'b0;
        halted  = 1'b0;
      end
    endcase
  end

  // Program counter: redirect target, sequential advance, or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= 64'd0;
    end else if (redirect_valid) begin
      pc_r <= align_pc(redirect_pc);
    end else if (fetch_s) begin
      pc_r <= pc_r + 64'(INSTR_BYTES);
    end else begin
      pc_r <= pc_r;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .enq       (fetch_s),
    .enq_data  (enq_data_s),
    .deq_ready (out_ready),
    .head_valid(out_valid),
    .head      (head_s),
    .deq       (deq_s),
    .count     (count_s)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam int DEPTH    = 4;
  localparam int MEM_SIZE = 1024;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        halted;
  logic        misalign_err;

  logic [31:0] mem [256];

  ent_t        m_q [$];
  logic [63:0] m_pc;
  logic        m_halted;

  int checks = 0;
  int errors = 0;

  instr_fetch_ctrl #(.DEPTH(DEPTH), .MEM_SIZE(MEM_SIZE)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 64'(MEM_SIZE)) imem_instr = mem[imem_addr[9:2]];
    else                           imem_instr = 32'h0;
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a < 64'(MEM_SIZE)) return mem[a[9:2]];
    return 32'h0;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_pc     = 64'd0;
    m_halted = 1'b0;
  endtask

  // Drive one cycle's inputs and return at the falling edge for sampling.
  task automatic set_in(input logic rv, input logic [63:0] rp, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
    @(negedge clk);
  endtask

  // Clock edge plus reference-model update from the inputs seen at that edge.
  task automatic adv();
    @(posedge clk);
    if (out_ready && m_q.size() != 0) void'(m_q.pop_front());
    if (redirect_valid) begin
      m_q.delete();
      m_pc     = {redirect_pc[63:2], 2'b00};
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_pc + 64'd3 >= 64'(MEM_SIZE)) begin
        m_halted = 1'b1;
      end else if (m_q.size() < DEPTH) begin
        m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 64'd4;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    #2;
    checks++;
    if (out_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 64'd0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b halted=%b addr=%h mis=%b, expected 0 0 0 0",
               out_valid, halted, imem_addr, misalign_err);
    end
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc;
    apply_reset();
    set_in(1'b0, 64'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 64'd0) begin
      errors++;
      $display("FAIL stream_first: valid=%b addr=%h, expected 0 0", out_valid, imem_addr);
    end
    adv();
    for (int k = 0; k < 4; k++) begin
      exp_pc = 64'(4 * k);
      set_in(1'b0, 64'd0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem[k]) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b pc=%h instr=%h, expected 1 %h %h",
                 k, out_valid, out_pc, out_instr, exp_pc, mem[k]);
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_addr;
    logic [63:0] exp_pc;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      exp_addr = (i < 4) ? 64'(4 * i) : 64'd16;
      set_in(1'b0, 64'd0, 1'b0);
      checks++;
      if (imem_addr !== exp_addr || out_valid !== (i != 0) || (i != 0 && out_pc !== 64'd0)) begin
        errors++;
        $display("FAIL stall_%0d: addr=%h valid=%b pc=%h, expected %h %b 0",
                 i, imem_addr, out_valid, out_pc, exp_addr, (i != 0));
      end
      adv();
    end
    for (int j = 0; j < 5; j++) begin
      exp_pc = 64'(4 * j);
      set_in(1'b0, 64'd0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem[j]) begin
        errors++;
        $display("FAIL drain_%0d: valid=%b pc=%h instr=%h, expected 1 %h %h",
                 j, out_valid, out_pc, out_instr, exp_pc, mem[j]);
      end
      adv();
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 64'd0, 1'b0);
      adv();
    end
    set_in(1'b1, 64'h40, 1'b0);
    checks++;
    if (misalign_err !== 1'b0 || out_pc !== 64'd0) begin
      errors++;
      $display("FAIL redir_pre: mis=%b pc=%h, expected 0 0", misalign_err, out_pc);
    end
    adv();
    set_in(1'b0, 64'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 64'h40) begin
      errors++;
      $display("FAIL redir_flush: valid=%b addr=%h, expected 0 40", out_valid, imem_addr);
    end
    adv();
    set_in(1'b0, 64'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_instr !== mem[16]) begin
      errors++;
      $display("FAIL redir_first: valid=%b pc=%h instr=%h, expected 1 40 %h",
               out_valid, out_pc, out_instr, mem[16]);
    end
    adv();
  endtask

  task automatic test_misalign();
    set_in(1'b1, 64'h42, 1'b1);
    checks++;
    if (misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_pulse: got %b expected 1", misalign_err);
    end
    adv();
    set_in(1'b0, 64'd0, 1'b1);
    checks++;
    if (misalign_err !== 1'b0 || imem_addr !== 64'h40) begin
      errors++;
      $display("FAIL misalign_after: mis=%b addr=%h, expected 0 40", misalign_err, imem_addr);
    end
    adv();
  endtask

  task automatic test_halt();
    logic seen_last;
    seen_last = 1'b0;
    set_in(1'b1, 64'd1008, 1'b1);
    adv();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 64'd0, 1'b1);
      if (out_valid && out_pc == 64'd1020) seen_last = 1'b1;
      checks++;
      if (halted !== m_halted || out_valid !== (m_q.size() != 0) ||
          (m_q.size() != 0 && out_pc !== m_q[0].pc)) begin
        errors++;
        $display("FAIL halt_seq_%0d: halted=%b valid=%b pc=%h, expected %b %b",
                 i, halted, out_valid, out_pc, m_halted, (m_q.size() != 0));
      end
      adv();
    end
    set_in(1'b0, 64'd0, 1'b1);
    checks++;
    if (!seen_last || halted !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 64'd1024) begin
      errors++;
      $display("FAIL halt_end: seen1020=%b halted=%b valid=%b addr=%h, expected 1 1 0 400",
               seen_last, halted, out_valid, imem_addr);
    end
    adv();
    set_in(1'b1, 64'd0, 1'b1);
    adv();
    set_in(1'b0, 64'd0, 1'b1);
    checks++;
    if (halted !== 1'b0 || imem_addr !== 64'd0) begin
      errors++;
      $display("FAIL halt_exit: halted=%b addr=%h, expected 0 0", halted, imem_addr);
    end
    adv();
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 64'd0, 1'b0);
      adv();
    end
    set_in(1'b0, 64'd0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || imem_addr !== 64'd8) begin
      errors++;
      $display("FAIL areset_pre: valid=%b addr=%h, expected 1 8", out_valid, imem_addr);
    end
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 64'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: valid=%b addr=%h halted=%b, expected 0 0 0",
               out_valid, imem_addr, halted);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(1'b0, 64'd0, 1'b1);
    adv();
    set_in(1'b0, 64'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'd0 || out_instr !== mem[0]) begin
      errors++;
      $display("FAIL areset_restart: valid=%b pc=%h instr=%h, expected 1 0 %h",
               out_valid, out_pc, out_instr, mem[0]);
    end
    adv();
  endtask

  task automatic test_random();
    logic        rv;
    logic        rdy;
    logic [63:0] rp;
    for (int i = 0; i < 600; i++) begin
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) rp = 64'($urandom_range(980, 1040));
      else                           rp = 64'($urandom_range(0, 1100));
      set_in(rv, rp, rdy);
      checks++;
      if (out_valid !== (m_q.size() != 0) || imem_addr !== m_pc || halted !== m_halted ||
          misalign_err !== (rv && rp[1:0] != 2'b00)) begin
        errors++;
        $display("FAIL rand_ctl_%0d: valid=%b addr=%h halted=%b mis=%b, expected %b %h %b %b",
                 i, out_valid, imem_addr, halted, misalign_err,
                 (m_q.size() != 0), m_pc, m_halted, (rv && rp[1:0] != 2'b00));
      end
      if (m_q.size() != 0) begin
        checks++;
        if (out_pc !== m_q[0].pc || out_instr !== m_q[0].instr) begin
          errors++;
          $display("FAIL rand_head_%0d: pc=%h instr=%h, expected %h %h",
                   i, out_pc, out_instr, m_q[0].pc, m_q[0].instr);
        end
      end
      adv();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter DEPTH, default 4: number of fetch-queue entries; power of two, at least 2.
REQ-002 Parameter MEM_SIZE, default 1024: instruction-memory size in bytes; power of two.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_addr  output  64  byte address presented to the combinational instruction memory.
REQ-006 imem_instr  input  32  instruction returned by memory in the same cycle as imem_addr.
REQ-007 redirect_valid  input  1  branch/flush request; takes effect this cycle.
REQ-008 redirect_pc  input  64  new fetch byte address, used when redirect_valid=1.
REQ-009 out_valid  output  1  the queue head holds a valid instruction.
REQ-010 out_ready  input  1  the consumer accepts the head this cycle.
REQ-011 out_instr  output  32  instruction at the queue head.
REQ-012 out_pc  output  64  byte address of the queue-head instruction.
REQ-013 halted  output  1  FSM is in HALTED.
REQ-014 misalign_err  output  1  one-cycle pulse on a redirect with redirect_pc[1:0]!=0.

Function
REQ-015 FSM states: FETCH and HALTED.
REQ-016 imem_addr SHALL equal pc in every state.
REQ-017 Fetch condition: state=FETCH, redirect_valid=0, pc+3<MEM_SIZE, and a queue slot is available (count<DEPTH, or count=DEPTH with a dequeue this cycle).
REQ-018 When the fetch condition holds, enqueue {pc, imem_instr} and set pc<=pc+4 at the edge.
REQ-019 When the fetch condition fails only because the queue is full, hold pc with no enqueue; no entry is lost or duplicated.
REQ-020 FETCH to HALTED when pc+3>=MEM_SIZE and redirect_valid=0; no enqueue in that cycle.
REQ-021 In HALTED, the queue continues to drain through the out handshake.
REQ-022 A dequeue occurs when out_valid and out_ready are both 1; the head advances at the edge.
REQ-023 out_valid=(count!=0); out_instr and out_pc are driven combinationally from the head entry.
REQ-024 On redirect_valid=1, in any state:
- the queue is flushed (count<=0);
- pc<=redirect_pc with bits [1:0] forced to 0;
- state<=FETCH;
- no enqueue occurs that cycle.
REQ-025 Redirect coincident with a dequeue: the dequeue counts as a completed transfer, and the flush still empties the queue.
REQ-026 misalign_err=1 for exactly the redirect cycle when redirect_pc[1:0]!=0.
REQ-027 Enqueue and dequeue in the same cycle leave count unchanged.
REQ-028 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-029 Throughput: one instruction per cycle sustained while out_ready=1 and memory is in range.
REQ-030 Latency: an instruction fetched in cycle N is visible at out_* in cycle N+1.

Reset
REQ-031 Asserting reset clears asynchronously: pc=0, state=FETCH, count=0, pointers=0, misalign_err=0, halted=0, out_valid=0.
REQ-032 Reset asserted mid-operation discards all queued entries; fetch resumes from address 0 on the first edge after release.

Structure
REQ-033 Package fetch_pkg holds:
- the fetch_state_t enum (FETCH, HALTED);
- the fq_entry_t struct {pc[63:0], instr[31:0]};
- the constant INSTR_BYTES=4.
REQ-034 The queue is one sub-module, fetch_queue: synchronous FIFO of fq_entry_t with flush, enq, deq, count.
REQ-035 The top level contains only the pc register, the FSM and the fetch-condition logic.

Verification
REQ-036 Release reset with out_ready=1 and memory words 0..3 = A,B,C,D -> out_pc 0,4,8,12 with out_instr A,B,C,D on consecutive cycles starting the cycle after the first edge.
REQ-037 Hold out_ready=0 for 10 cycles -> count saturates at 4, imem_addr holds at 16, out_pc stays 0; raise out_ready -> entries 0,4,8,12 then 16 with none lost.
REQ-038 Redirect to 0x40 while count=3 -> next cycle count=0 and imem_addr=0x40; the first out_pc after the redirect is 0x40.
REQ-039 Redirect to 0x42 -> misalign_err pulses for one cycle and pc becomes 0x40.
REQ-040 Fetch sequentially up to 1020 (MEM_SIZE=1024):
- 1020 is fetched; at pc=1024 halted=1 and the queue drains;
- a redirect to 0 returns to FETCH with halted=0.
REQ-041 Assert reset asynchronously mid-cycle with count=2 -> out_valid=0 immediately; after release, fetch restarts at address 0.
